ahb_mbox_monitor: RTL and testbench
===================================

// Module: ahb_mbox_monitor
// PURPOSE
//  Downstream consumer of the LSU AHB-Lite master in the SweRV bench: passively snoops LSU
//  write traffic, decodes writes to the mailbox address and turns them into a console
//  character stream (valid/ready FIFO) plus sticky pass/fail/done status for the bench.
//  Never drives the bus.
// PARAMETERS
//  MBOX_ADDR    32'hD058_0000  mailbox byte address; match on [31:3], lane = haddr[2:0]
//  FIFO_DEPTH   16             console FIFO entries, power of 2, >= 2
//  WDOG_CYCLES  32'h0000_8000  idle cycles before timeout (MBOX_WATCHDOG_EN only)
// PORTS
//  clk          in   1   core clock
//  rst          in   1   synchronous reset, active-high
//  haddr        in   32  snooped LSU HADDR
//  htrans       in   2   snooped HTRANS
//  hwrite       in   1   snooped HWRITE
//  hsize        in   3   snooped HSIZE (captured only; byte taken from lane)
//  hwdata       in   64  snooped HWDATA
//  hready       in   1   snooped HREADY (slave HREADYOUT)
//  char_valid   out  1   FIFO head valid
//  char_data    out  8   FIFO head byte
//  char_ready   in   1   consumer pops head when char_valid & char_ready
//  test_pass    out  1   sticky: 0xFF written
//  test_fail    out  1   sticky: 0x01 written
//  test_timeout out  1   sticky: watchdog expired (0 without MBOX_WATCHDOG_EN)
//  done         out  1   test_pass | test_fail | test_timeout
//  overflow     out  1   sticky: printable byte dropped, FIFO full
//  wr_count     out  32  completed mailbox writes, saturating at 32'hFFFF_FFFF
// BEHAVIOUR
//  - One clock (clk); reset is synchronous, active-high. While rst=1: every output 0,
//    FIFO empty, pending flag 0, FSM = RUN, watchdog counter 0.
//  - Address phase accepted when hready & htrans[1] & hwrite & haddr[31:3]==MBOX_ADDR[31:3]:
//    set pend, latch lane = haddr[2:0].
//  - Data phase completes on the first later cycle with pend & hready; byte =
//    hwdata[8*lane +: 8]. pend clears, unless a new matching address phase is accepted that
//    same cycle (back-to-back pipelined writes), in which case pend stays and lane reloads.
//  - Wait states (hready=0) hold pend and lane; hwdata is sampled only at completion.
//  - Classification of a completed byte b (FSM = RUN):
//    0xFF -> PASS; 0x01 -> FAIL;
//    0x20..0x7E or 0x0A -> push FIFO; any other value -> counted only.
//  - FSM: RUN -> PASS | FAIL | TIMEOUT, all terminal until rst. In a terminal state,
//    completed writes still count and FIFO drain continues; nothing more is pushed.
//  - FIFO: char_data/char_valid registered; a byte completed at cycle N is visible at N+1.
//    Push when full with no pop: byte dropped, overflow set. Push and pop on the same cycle
//    when full: both take effect, no overflow. Pop when empty: ignored. Pointers wrap mod
//    FIFO_DEPTH with an extra wrap bit for full/empty.
//  - wr_count increments once per completed mailbox write, including 0xFF and 0x01.
// CONFIGURATION
//  MBOX_WATCHDOG_EN defined: 32-bit idle counter clears on each completed mailbox write
//    and increments otherwise while FSM = RUN. At count == WDOG_CYCLES-1 the FSM goes to
//    TIMEOUT and test_timeout is set the next cycle. A write completing that same cycle
//    wins: it is classified and the counter clears.
//  Undefined: no counter; test_timeout tied 0; FSM never enters TIMEOUT.
// STRUCTURE
//  mbox_pkg: MBOX_PASS_CODE=8'hFF, MBOX_FAIL_CODE=8'h01, HTRANS_NONSEQ/SEQ constants,
//    typedef enum logic [1:0] {MB_RUN, MB_PASS, MB_FAIL, MB_TIMEOUT} mbox_state_e.
//  Sub-module mbox_char_fifo (DEPTH, WIDTH=8; push/pop/full/empty/dout): synchronous FIFO.
//  Top level holds the AHB phase tracker, classifier, FSM, counters and watchdog.
// TESTING
//  1 Single NONSEQ write 0x41 to 0xD0580000, hready=1 -> char_valid=1, char_data=0x41 one
//    cycle after the data phase; wr_count=1.
//  2 Back-to-back writes "Hi\n" with 2 wait states on the middle one, char_ready=1 ->
//    0x48, 0x69, 0x0A popped in order; no byte lost or duplicated.
//  3 Write 0x41 to 0xD0580004 (lane 4, hwdata[39:32]) and to 0xD0580008 -> first pushed,
//    second ignored; wr_count=1.
//  4 char_ready=0, 17 printable writes, FIFO_DEPTH=16 -> 16 held, overflow=1; simultaneous
//    push+pop when full -> no overflow change.
//  5 Write 0xFF -> test_pass=1, done=1; then 0x01 and 0x42 -> test_fail=0, no push,
//    wr_count=3; rst=1 for 1 cycle -> all outputs 0.
//  6 MBOX_WATCHDOG_EN, WDOG_CYCLES=100, no writes -> test_timeout=1 after 100 cycles;
//    write on cycle 99 -> no timeout, counter restarts.

Source files
------------

// File: rtl/mbox_pkg.sv
// Shared constants, FSM state type and byte classifier for the AHB mailbox monitor.
package mbox_pkg;

  localparam logic [7:0] MBOX_PASS_CODE = 8'hFF;
  localparam logic [7:0] MBOX_FAIL_CODE = 8'h01;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    MB_RUN     = 2'd0,
    MB_PASS    = 2'd1,
    MB_FAIL    = 2'd2,
    MB_TIMEOUT = 2'd3
  } mbox_state_e;

  // Console-worthy bytes: printable ASCII plus line feed.
  function automatic logic is_printable(input logic [7:0] b);
    return ((b >= 8'h20) && (b <= 8'h7E)) || (b == 8'h0A);
  endfunction

endpackage

// File: rtl/mbox_char_fifo.sv
// Synchronous console FIFO; pointers carry an extra wrap bit to tell full from empty.
module mbox_char_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en_s;
  logic             rd_en_s;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign wr_en_s = push & (~full | pop);
  assign rd_en_s = pop & ~empty;
  assign dout    = empty ? {WIDTH{1'b0}} : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_en_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ahb_mbox_monitor.sv
// Passive AHB-Lite snooper turning mailbox writes into a console stream and test status.
// Optional idle watchdog enabled by defining MBOX_WATCHDOG_EN.
module ahb_mbox_monitor
  import mbox_pkg::*;
#(
  parameter logic [31:0] MBOX_ADDR   = 32'hD058_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] WDOG_CYCLES = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [63:0] hwdata,
  input  logic        hready,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        test_pass,
  output logic        test_fail,
  output logic        test_timeout,
  output logic        done,
  output logic        overflow,
  output logic [31:0] wr_count
);

  mbox_state_e state_q, state_d;
  logic        pend_q, pend_d;
  logic [2:0]  lane_q, lane_d;
  logic        overflow_q, overflow_d;
  logic [31:0] wr_count_q, wr_count_d;

  logic        addr_hit_s;
  logic        complete_s;
  logic [7:0]  wbyte_s;
  logic        push_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        wdog_fire_s;
  logic        unused_hsize_s;

  // Transfer size is irrelevant: the byte is picked purely by address lane.
  assign unused_hsize_s = ^hsize;

  assign addr_hit_s = hready & hwrite
                    & ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ))
                    & (haddr[31:3] == MBOX_ADDR[31:3]);
  assign complete_s = pend_q & hready;
  assign wbyte_s    = hwdata[{lane_q, 3'b000} +: 8];

`ifdef MBOX_WATCHDOG_EN
  logic [31:0] wdog_q, wdog_d;

  // Idle counter only runs while the test is live; a completing write always wins.
  always_comb begin
    wdog_d      = wdog_q;
    wdog_fire_s = 1'b0;
    if (state_q != MB_RUN) begin
      wdog_d = wdog_q;
    end else if (complete_s) begin
      wdog_d = 32'd0;
    end else if (wdog_q == (WDOG_CYCLES - 32'd1)) begin
      wdog_fire_s = 1'b1;
    end else begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= 32'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_wdog_s;

  assign unused_wdog_s = ^WDOG_CYCLES;
  assign wdog_fire_s   = 1'b0;
`endif

  always_comb begin
    pend_d     = pend_q;
    lane_d     = lane_q;
    state_d    = state_q;
    push_s     = 1'b0;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;

    // A new address phase on the completing cycle keeps the pipeline primed.
    if (addr_hit_s) begin
      pend_d = 1'b1;
      lane_d = haddr[2:0];
    end else if (complete_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (complete_s && (wr_count_q != 32'hFFFF_FFFF)) begin
      wr_count_d = wr_count_q + 32'd1;
    end else begin
      wr_count_d = wr_count_q;
    end

    case (state_q)
      MB_RUN: begin
        if (complete_s) begin
          if (wbyte_s == MBOX_PASS_CODE) begin
            state_d = MB_PASS;
          end else if (wbyte_s == MBOX_FAIL_CODE) begin
            state_d = MB_FAIL;
          end else if (is_printable(wbyte_s)) begin
            push_s = 1'b1;
          end else begin
            push_s = 1'b0;
          end
        end else if (wdog_fire_s) begin
          state_d = MB_TIMEOUT;
        end else begin
          state_d = MB_RUN;
        end
      end
      MB_PASS, MB_FAIL, MB_TIMEOUT: state_d = state_q;
      default: state_d = MB_RUN;
    endcase

    if (push_s && fifo_full_s && !char_ready) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MB_RUN;
      pend_q     <= 1'b0;
      lane_q     <= 3'd0;
      overflow_q <= 1'b0;
      wr_count_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      lane_q     <= lane_d;
      overflow_q <= overflow_d;
      wr_count_q <= wr_count_d;
    end
  end

  mbox_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (char_ready),
    .din   (wbyte_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .dout  (char_data)
  );

  assign char_valid   = ~fifo_empty_s;
  assign test_pass    = (state_q == MB_PASS);
  assign test_fail    = (state_q == MB_FAIL);
  assign test_timeout = (state_q == MB_TIMEOUT);
  assign done         = (state_q != MB_RUN);
  assign overflow     = overflow_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_ahb_mbox_monitor.sv
// Scoreboard bench for ahb_mbox_monitor; covers the watchdog when MBOX_WATCHDOG_EN is defined.
module tb_ahb_mbox_monitor;

  localparam logic [31:0] MBOX = 32'hD058_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  logic        hready;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        test_pass;
  logic        test_fail;
  logic        test_timeout;
  logic        done;
  logic        overflow;
  logic [31:0] wr_count;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;

  always #5 clk = ~clk;

  ahb_mbox_monitor #(
    .MBOX_ADDR   (MBOX),
    .FIFO_DEPTH  (16),
    .WDOG_CYCLES (32'd100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .haddr        (haddr),
    .htrans       (htrans),
    .hwrite       (hwrite),
    .hsize        (hsize),
    .hwdata       (hwdata),
    .hready       (hready),
    .char_valid   (char_valid),
    .char_data    (char_data),
    .char_ready   (char_ready),
    .test_pass    (test_pass),
    .test_fail    (test_fail),
    .test_timeout (test_timeout),
    .done         (done),
    .overflow     (overflow),
    .wr_count     (wr_count)
  );

  // Consumer side: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && char_valid && char_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got %h expected none", char_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (char_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data got %h expected %h", char_data, mon_exp);
        end
      end
    end
  end

  function automatic logic [63:0] lane_data(input logic [2:0] lane, input logic [7:0] b);
    logic [63:0] d;
    d = {8{8'h5A}};
    d[8*lane +: 8] = b;
    return d;
  endfunction

  task automatic drive(input logic av, input logic [31:0] a, input logic [63:0] wd,
                       input logic rdy);
    htrans = av ? 2'b10 : 2'b00;
    haddr  = a;
    hwrite = av;
    hwdata = wd;
    hready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [31:0] a, input logic [7:0] b);
    drive(1'b1, a, 64'd0, 1'b1);
    drive(1'b0, 32'd0, lane_data(a[2:0], b), 1'b1);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    char_ready = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({char_valid, char_data, test_pass, test_fail, test_timeout, done, overflow, wr_count}
        !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h p=%b f=%b t=%b dn=%b o=%b c=%0d expected all 0",
               char_valid, char_data, test_pass, test_fail, test_timeout, done, overflow,
               wr_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, MBOX, 64'd0, 1'b1);
    checks++;
    if (char_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid got %b expected 0", char_valid);
    end
    drive(1'b0, 32'd0, lane_data(3'd0, 8'h41), 1'b1);
    checks++;
    if (char_valid !== 1'b1 || char_data !== 8'h41 || wr_count !== 32'd1) begin
      errors++;
      $display("FAIL single_write got v=%b d=%h c=%0d expected v=1 d=41 c=1",
               char_valid, char_data, wr_count);
    end
    exp_q.push_back(8'h41);
    char_ready = 1'b1;
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    char_ready = 1'b0;
    checks++;
    if (char_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain got v=%b pending=%0d expected v=0 pending=0",
               char_valid, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    char_ready = 1'b1;
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    exp_q.push_back(8'h0A);
    drive(1'b1, MBOX,         64'd0,                     1'b1);
    drive(1'b1, MBOX + 32'd3, lane_data(3'd0, 8'h48),    1'b1);
    drive(1'b1, MBOX + 32'd7, lane_data(3'd3, 8'h3F),    1'b0);
    drive(1'b1, MBOX + 32'd7, lane_data(3'd3, 8'h3F),    1'b0);
    drive(1'b1, MBOX + 32'd7, lane_data(3'd3, 8'h69),    1'b1);
    drive(1'b0, 32'd0,        lane_data(3'd7, 8'h0A),    1'b1);
    repeat (4) drive(1'b0, 32'd0, 64'd0, 1'b1);
    char_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || char_valid !== 1'b0 || wr_count !== 32'd3) begin
      errors++;
      $display("FAIL b2b_stream got pending=%0d v=%b c=%0d expected pending=0 v=0 c=3",
               exp_q.size(), char_valid, wr_count);
    end
  endtask

  task automatic test_lanes();
    do_reset();
    char_ready = 1'b1;
    exp_q.push_back(8'h41);
    write1(MBOX + 32'd4, 8'h41);
    write1(MBOX + 32'd8, 8'h41);
    repeat (2) drive(1'b0, 32'd0, 64'd0, 1'b1);
    char_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || char_valid !== 1'b0 || wr_count !== 32'd1) begin
      errors++;
      $display("FAIL lane_decode got pending=%0d v=%b c=%0d expected pending=0 v=0 c=1",
               exp_q.size(), char_valid, wr_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      write1(MBOX, 8'h41 + 8'(i));
      exp_q.push_back(8'h41 + 8'(i));
    end
    checks++;
    if (overflow !== 1'b0 || char_valid !== 1'b1 || char_data !== 8'h41) begin
      errors++;
      $display("FAIL fifo_fill got o=%b v=%b d=%h expected o=0 v=1 d=41",
               overflow, char_valid, char_data);
    end
    exp_q.push_back(8'h71);
    drive(1'b1, MBOX, 64'd0, 1'b1);
    char_ready = 1'b1;
    drive(1'b0, 32'd0, lane_data(3'd0, 8'h71), 1'b1);
    char_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0 || char_data !== 8'h42) begin
      errors++;
      $display("FAIL full_push_pop got o=%b head=%h expected o=0 head=42", overflow, char_data);
    end
    write1(MBOX, 8'h7A);
    checks++;
    if (overflow !== 1'b1 || wr_count !== 32'd18) begin
      errors++;
      $display("FAIL overflow_set got o=%b c=%0d expected o=1 c=18", overflow, wr_count);
    end
    char_ready = 1'b1;
    repeat (20) drive(1'b0, 32'd0, 64'd0, 1'b1);
    char_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || char_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain got pending=%0d v=%b o=%b expected pending=0 v=0 o=1",
               exp_q.size(), char_valid, overflow);
    end
  endtask

  task automatic test_status();
    do_reset();
    write1(MBOX, 8'hFF);
    checks++;
    if (test_pass !== 1'b1 || done !== 1'b1 || test_fail !== 1'b0 || char_valid !== 1'b0 ||
        wr_count !== 32'd1) begin
      errors++;
      $display("FAIL pass_code got p=%b dn=%b f=%b v=%b c=%0d expected p=1 dn=1 f=0 v=0 c=1",
               test_pass, done, test_fail, char_valid, wr_count);
    end
    write1(MBOX, 8'h01);
    write1(MBOX, 8'h42);
    checks++;
    if (test_pass !== 1'b1 || test_fail !== 1'b0 || char_valid !== 1'b0 ||
        wr_count !== 32'd3) begin
      errors++;
      $display("FAIL terminal_hold got p=%b f=%b v=%b c=%0d expected p=1 f=0 v=0 c=3",
               test_pass, test_fail, char_valid, wr_count);
    end
    rst = 1'b1;
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    rst = 1'b0;
    checks++;
    if ({char_valid, test_pass, test_fail, test_timeout, done, overflow, wr_count} !== 38'd0) begin
      errors++;
      $display("FAIL status_reset got v=%b p=%b f=%b t=%b dn=%b o=%b c=%0d expected all 0",
               char_valid, test_pass, test_fail, test_timeout, done, overflow, wr_count);
    end
    write1(MBOX + 32'd2, 8'h07);
    checks++;
    if (char_valid !== 1'b0 || wr_count !== 32'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL nonprint got v=%b c=%0d dn=%b expected v=0 c=1 dn=0",
               char_valid, wr_count, done);
    end
    write1(MBOX + 32'd5, 8'h01);
    checks++;
    if (test_fail !== 1'b1 || test_pass !== 1'b0 || done !== 1'b1 || wr_count !== 32'd2) begin
      errors++;
      $display("FAIL fail_code got f=%b p=%b dn=%b c=%0d expected f=1 p=0 dn=1 c=2",
               test_fail, test_pass, done, wr_count);
    end
  endtask

  task automatic test_watchdog();
`ifdef MBOX_WATCHDOG_EN
    do_reset();
    repeat (99) drive(1'b0, 32'd0, 64'd0, 1'b1);
    checks++;
    if (test_timeout !== 1'b0) begin
      errors++;
      $display("FAIL wdog_early got %b expected 0", test_timeout);
    end
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    checks++;
    if (test_timeout !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL wdog_fire got t=%b dn=%b expected t=1 dn=1", test_timeout, done);
    end
    do_reset();
    repeat (98) drive(1'b0, 32'd0, 64'd0, 1'b1);
    write1(MBOX, 8'h41);
    checks++;
    if (test_timeout !== 1'b0 || wr_count !== 32'd1) begin
      errors++;
      $display("FAIL wdog_write_wins got t=%b c=%0d expected t=0 c=1", test_timeout, wr_count);
    end
    repeat (99) drive(1'b0, 32'd0, 64'd0, 1'b1);
    checks++;
    if (test_timeout !== 1'b0) begin
      errors++;
      $display("FAIL wdog_restart_early got %b expected 0", test_timeout);
    end
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    checks++;
    if (test_timeout !== 1'b1) begin
      errors++;
      $display("FAIL wdog_restart_fire got %b expected 1", test_timeout);
    end
`else
    do_reset();
    repeat (150) drive(1'b0, 32'd0, 64'd0, 1'b1);
    checks++;
    if (test_timeout !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL no_wdog got t=%b dn=%b expected t=0 dn=0", test_timeout, done);
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    haddr      = 32'd0;
    htrans     = 2'b00;
    hwrite     = 1'b0;
    hsize      = 3'd0;
    hwdata     = 64'd0;
    hready     = 1'b1;
    char_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_lanes();
    test_overflow();
    test_status();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
